// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: sequencer states, register numbers, bit positions and ExcCodes.
package cp0_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        X_EPC      = 3'd1,
        X_CAUSE    = 3'd2,
        X_BADV     = 3'd3,
        X_STATUS   = 3'd4,
        E_STATUS   = 3'd5,
        REDIR      = 3'd6
    } cp0_state_e;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int          STATUS_EXL_BIT  = 1;
    localparam int          CAUSE_BD_BIT    = 31;
    localparam logic [31:0] STATUS_EXL_MASK = 32'h1 << STATUS_EXL_BIT;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0_exc_seq.sv
// Exception/ERET sequencer driving the CP0 write port, then redirecting fetch.
// Define CP0_BADVADDR_EN to add the BadVAddr write for AdEL/AdES.
module cp0_exc_seq
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter logic [4:0]  STATUS_ADDR   = REG_STATUS,
    parameter logic [4:0]  CAUSE_ADDR    = REG_CAUSE,
    parameter logic [4:0]  EPC_ADDR      = REG_EPC,
    parameter logic [4:0]  BADVADDR_ADDR = REG_BADVADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_req,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [4:0]  cp0_addrW,
    output logic [5:0]  cp0_selW,
    output logic [31:0] cp0_din,
    output logic        cp0_write,
    output logic [4:0]  cp0_addrR,
    output logic [5:0]  cp0_selR,
    input  logic [31:0] cp0_dout,
    input  logic [31:0] epc
);

    cp0_state_e  state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [31:0] target_q, target_d;

`ifdef CP0_BADVADDR_EN
    logic [31:0] badv_q, badv_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            badv_q <= '0;
        end else begin
            badv_q <= badv_d;
        end
    end

    always_comb begin
        badv_d = badv_q;
        if (!rst && state_q == IDLE && exc_req) begin
            badv_d = exc_badvaddr;
        end
    end
`else
    logic unused_badvaddr;
    assign unused_badvaddr = ^{exc_badvaddr, BADVADDR_ADDR};
`endif

    assign cp0_selW = 6'd0;
    assign cp0_selR = 6'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            code_q   <= '0;
            pc_q     <= '0;
            bd_q     <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            bd_q     <= bd_d;
            target_q <= target_d;
        end
    end

    // Outputs are forced idle while rst is high so an aborted sequence never writes in the reset cycle.
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        pc_d           = pc_q;
        bd_d           = bd_q;
        target_d       = target_q;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cp0_addrW      = '0;
        cp0_din        = '0;
        cp0_write      = 1'b0;
        cp0_addrR      = STATUS_ADDR;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (exc_req) begin
                        code_d  = exc_code;
                        pc_d    = exc_pc;
                        bd_d    = exc_bd;
                        state_d = X_EPC;
                    end else if (eret_req) begin
                        state_d = E_STATUS;
                    end
                end
                X_EPC: begin
                    stall = 1'b1;
                    flush = 1'b1;
                    // A nested exception (EXL already set) must keep the original EPC.
                    if (!cp0_dout[STATUS_EXL_BIT]) begin
                        cp0_write = 1'b1;
                        cp0_addrW = EPC_ADDR;
                        cp0_din   = bd_q ? (pc_q - 32'd4) : pc_q;
                    end
                    state_d = X_CAUSE;
                end
                X_CAUSE: begin
                    stall     = 1'b1;
                    cp0_addrR = CAUSE_ADDR;
                    cp0_write = 1'b1;
                    cp0_addrW = CAUSE_ADDR;
                    cp0_din   = {bd_q, 15'b0, cp0_dout[15:8], 1'b0, code_q, 2'b0};
`ifdef CP0_BADVADDR_EN
                    state_d   = (code_q == EXC_ADEL || code_q == EXC_ADES) ? X_BADV : X_STATUS;
`else
                    state_d   = X_STATUS;
`endif
                end
`ifdef CP0_BADVADDR_EN
                X_BADV: begin
                    stall     = 1'b1;
                    cp0_write = 1'b1;
                    cp0_addrW = BADVADDR_ADDR;
                    cp0_din   = badv_q;
                    state_d   = X_STATUS;
                end
`endif
                X_STATUS: begin
                    stall     = 1'b1;
                    cp0_write = 1'b1;
                    cp0_addrW = STATUS_ADDR;
                    cp0_din   = cp0_dout | STATUS_EXL_MASK;
                    target_d  = EXC_VECTOR;
                    state_d   = REDIR;
                end
                E_STATUS: begin
                    stall     = 1'b1;
                    flush     = 1'b1;
                    cp0_write = 1'b1;
                    cp0_addrW = STATUS_ADDR;
                    cp0_din   = cp0_dout & ~STATUS_EXL_MASK;
                    target_d  = epc;
                    state_d   = REDIR;
                end
                REDIR: begin
                    stall          = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                    state_d        = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Randomized scoreboard bench for cp0_exc_seq against a transaction-level model of the CP0 effects.
module tb_cp0_exc_seq;
    import cp0_pkg::*;

    localparam int K_FLUSH = 0;
    localparam int K_WR    = 1;
    localparam int K_REDIR = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req, exc_bd, eret_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr;
    logic        stall, flush, redirect_valid, cp0_write;
    logic [31:0] redirect_pc, cp0_din, cp0_dout, epc;
    logic [4:0]  cp0_addrW, cp0_addrR;
    logic [5:0]  cp0_selW, cp0_selR;

    logic [31:0] rf  [32];
    logic [31:0] mdl [32];
    logic        tb_wr;
    logic [4:0]  tb_waddr;
    logic [31:0] tb_wdat;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    ev_t         q[$];
    bit          badv_en;

    always #5 clk = ~clk;

    cp0_exc_seq dut (
        .clk(clk), .rst(rst),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .exc_badvaddr(exc_badvaddr), .eret_req(eret_req),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cp0_addrW(cp0_addrW), .cp0_selW(cp0_selW), .cp0_din(cp0_din), .cp0_write(cp0_write),
        .cp0_addrR(cp0_addrR), .cp0_selR(cp0_selR), .cp0_dout(cp0_dout), .epc(epc)
    );

    // Behavioural CP0 register file the sequencer talks to.
    assign cp0_dout = rf[cp0_addrR];
    assign epc      = rf[14];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tb_wr) rf[tb_waddr] <= tb_wdat;
        else if (cp0_write) rf[cp0_addrW] <= cp0_din;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push_ev(input int kind, input logic [4:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, input logic [4:0] a, input logic [31:0] d);
        ev_t e;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %h at cycle %0d, want none", kind, a, d, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", kind, e.kind);
            if (e.kind != K_FLUSH) begin
                chk("ev_addr", {27'b0, a}, {27'b0, e.addr});
                chk("ev_data", d, e.data);
            end
            chk("ev_cycle", cyc, e.cyc);
        end
    endtask

    task automatic set_reg(input logic [4:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        tb_wr = 1'b1; tb_waddr = a; tb_wdat = v;
        @(posedge clk); #1;
        tb_wr = 1'b0;
        mdl[a] = v;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (n < 20 && (stall !== 1'b0 || q.size() != 0)) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_stall_released"}, {31'b0, stall}, 32'h0);
        chk({nm, "_all_events_seen"}, q.size(), 0);
        q.delete();
    endtask

    // Reference: what the CP0 file and fetch must see for one exception accepted at edge into cycle a.
    task automatic model_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                             input logic [31:0] badv, input int a);
        logic [31:0] cause;
        int n;
        push_ev(K_FLUSH, 5'd0, 32'h0, a);
        if (mdl[12][1] == 1'b0) begin
            mdl[14] = bd ? pc - 32'd4 : pc;
            push_ev(K_WR, 5'd14, mdl[14], a);
        end
        cause = ({31'b0, bd} << 31) | (mdl[13] & 32'h0000FF00) | ({27'b0, code} << 2);
        mdl[13] = cause;
        push_ev(K_WR, 5'd13, cause, a + 1);
        n = a + 2;
        if (badv_en && (code == 5'd4 || code == 5'd5)) begin
            mdl[8] = badv;
            push_ev(K_WR, 5'd8, badv, n);
            n++;
        end
        mdl[12] = mdl[12] | 32'h2;
        push_ev(K_WR, 5'd12, mdl[12], n);
        push_ev(K_REDIR, 5'd0, VEC, n + 1);
    endtask

    task automatic model_eret(input int a);
        push_ev(K_FLUSH, 5'd0, 32'h0, a);
        mdl[12] = mdl[12] & ~32'h2;
        push_ev(K_WR, 5'd12, mdl[12], a);
        push_ev(K_REDIR, 5'd0, mdl[14], a + 1);
    endtask

    // kind: 0 exception, 1 ERET, 2 both at once (exception must win).
    task automatic issue(input string nm, input int kind, input logic [4:0] code, input logic [31:0] pc,
                         input logic bd, input logic [31:0] badv, input int hold);
        int a;
        @(posedge clk); #1;
        a = cyc + 1;
        exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = badv;
        exc_req  = (kind != 1);
        eret_req = (kind != 0);
        if (kind == 1) model_eret(a);
        else model_exc(code, pc, bd, badv, a);
        repeat (hold) @(posedge clk);
        #1;
        exc_req = 1'b0; eret_req = 1'b0;
        wait_idle(nm);
    endtask

    initial begin
        logic [4:0] codes [7];
        int a;
        int r;
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
`ifdef CP0_BADVADDR_EN
        badv_en = 1'b1;
`else
        badv_en = 1'b0;
`endif
        rst = 1'b1; exc_req = 1'b0; eret_req = 1'b0; exc_code = '0; exc_pc = '0;
        exc_bd = 1'b0; exc_badvaddr = '0; tb_wr = 1'b0; tb_waddr = '0; tb_wdat = '0;

        fork
            forever begin
                @(negedge clk);
                if (flush === 1'b1) pop_ev(K_FLUSH, 5'd0, 32'h0);
                if (cp0_write === 1'b1) begin
                    chk("sel_w", {26'b0, cp0_selW}, 32'h0);
                    pop_ev(K_WR, cp0_addrW, cp0_din);
                end
                if (redirect_valid === 1'b1) begin
                    chk("stall_on_redirect", {31'b0, stall}, 32'h1);
                    pop_ev(K_REDIR, 5'd0, redirect_pc);
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'h0);
        chk("rst_write", {31'b0, cp0_write}, 32'h0);
        chk("rst_addr_r", {27'b0, cp0_addrR}, 32'd12);
        chk("rst_sel_r", {26'b0, cp0_selR}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        set_reg(5'd8, 32'h0);
        set_reg(5'd12, 32'h0);
        set_reg(5'd13, 32'h0);
        set_reg(5'd14, 32'h0);

        issue("syscall", 0, 5'd8, 32'h80001000, 1'b0, 32'h0, 1);
        chk("syscall_epc", rf[14], 32'h80001000);
        chk("syscall_cause", rf[13], 32'h00000020);
        chk("syscall_status", rf[12], 32'h2);

        set_reg(5'd12, 32'h0);
        issue("delay_slot", 0, 5'd8, 32'h80001004, 1'b1, 32'h0, 2);
        chk("ds_epc", rf[14], 32'h80001000);
        chk("ds_cause_bd", {31'b0, rf[13][31]}, 32'h1);

        issue("nested", 0, 5'd12, 32'h80005550, 1'b0, 32'h0, 1);
        chk("nested_epc_kept", rf[14], 32'h80001000);
        chk("nested_cause_code", {27'b0, rf[13][6:2]}, 32'd12);

        set_reg(5'd14, 32'h80002000);
        set_reg(5'd12, 32'h3);
        issue("eret", 1, 5'd0, 32'h0, 1'b0, 32'h0, 1);
        chk("eret_status", rf[12], 32'h1);

        set_reg(5'd12, 32'h0);
        issue("exc_and_eret", 2, 5'd4, 32'h80003000, 1'b0, 32'h1235, 2);
        chk("both_badvaddr", rf[8], badv_en ? 32'h1235 : 32'h0);

        // Reset landing in X_CAUSE: only the EPC write and flush may appear.
        set_reg(5'd12, 32'h0);
        @(posedge clk); #1;
        a = cyc + 1;
        exc_req = 1'b1; exc_code = 5'd10; exc_pc = 32'h80004000; exc_bd = 1'b0;
        push_ev(K_FLUSH, 5'd0, 32'h0, a);
        push_ev(K_WR, 5'd14, 32'h80004000, a);
        mdl[14] = 32'h80004000;
        @(posedge clk); #1;
        exc_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_cycle_write", {31'b0, cp0_write}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'b0, stall}, 32'h0);
        chk("abort_redirect", {31'b0, redirect_valid}, 32'h0);
        repeat (8) @(negedge clk);
        chk("abort_events", q.size(), 0);
        q.delete();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_reg(5'd12, $urandom & 32'hFFFFFF03);
                set_reg(5'd13, $urandom);
                set_reg(5'd14, $urandom & 32'hFFFFFFFC);
            end
            r = $urandom_range(0, 9);
            issue("rand", (r < 6) ? 0 : ((r < 8) ? 1 : 2),
                  codes[$urandom_range(0, 6)], $urandom & 32'hFFFFFFFC,
                  1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 3));
        end

        chk("final_status", rf[12], mdl[12]);
        chk("final_cause", rf[13], mdl[13]);
        chk("final_epc", rf[14], mdl[14]);
        chk("final_badvaddr", rf[8], mdl[8]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
